popcnt_seq_ctrl: RTL and testbench
==================================

// Module: popcnt_seq_ctrl
// PURPOSE
//   Sequencing controller that counts the ones in a wide word by time-sharing one
//   onesin6 popcount unit. Each cycle it feeds one 6-bit chunk to onesin6 and adds
//   the 3-bit result into an accumulator.
//   Sits between a valid/ready word producer and a valid/ready count consumer.
// PARAMETERS
//   CHUNKS  4  number of 6-bit chunks per word; in_data width = 6*CHUNKS (>=1)
//   CNT_W   5  accumulator/result width; must satisfy 2**CNT_W > 6*CHUNKS
// PORTS
//   clk        in   1         single clock; all state updates on posedge
//   rst        in   1         synchronous, active-high reset
//   in_valid   in   1         producer has a word on in_data
//   in_ready   out  1         controller can accept a word (IDLE only)
//   in_data    in   6*CHUNKS  word to count; chunk k = in_data[6k+5:6k]
//   out_valid  out  1         out_count holds a finished result
//   out_ready  in   1         consumer takes the result
//   out_count  out  CNT_W     number of ones in the accepted word
//   busy       out  1         high in RUN or DONE
// BEHAVIOUR
//   - Reset (sampled at posedge with rst=1): state=IDLE, acc=0, idx=0, shift reg=0,
//     out_valid=0, out_count=0, busy=0. The in-flight word and the pending result
//     are discarded. Reset overrides every other input in that cycle.
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready=1. If in_valid=1 at the edge (accept), then:
//     shift reg<=in_data, acc<=0, idx<=0, next state RUN. Otherwise stay in IDLE.
//   - RUN: in_ready=0. onesin6 input = shift reg[5:0]. Each edge:
//     acc<=acc+zero-extended onesin6 out, shift reg>>=6, idx<=idx+1.
//     When idx==CHUNKS-1, the same edge adds the last chunk and moves to DONE.
//   - DONE: out_valid=1, out_count=acc, held stable until out_ready=1 at an edge,
//     then next state IDLE. out_valid drops on that edge.
//   - Latency: out_valid rises exactly CHUNKS edges after the accept edge.
//     Minimum spacing between accepts is CHUNKS+2 cycles (RUN x CHUNKS, DONE >=1,
//     IDLE >=1).
//   - in_valid while busy: ignored, no capture. The producer must hold the word
//     until in_ready&in_valid.
//   - out_ready while not DONE: ignored.
//   - out_count is a registered copy of acc. It is 0 after reset, it is not
//     meaningful while out_valid=0, and it never changes while out_valid=1.
//   - Arithmetic: acc is CNT_W bits and unsigned; the CNT_W parameter rule
//     guarantees it cannot overflow. idx width = clog2(CHUNKS), minimum 1 bit.
//   - All outputs are registered or decoded only from the state register, so
//     there are no combinational paths from inputs to outputs.
// STRUCTURE
//   - popcnt_pkg: CHUNK_W=6, the state encodings (IDLE=2'd0, RUN=2'd1,
//     DONE=2'd2), and a clog2 function.
//   - Sub-module: one instance of the existing onesin6 (6-bit in, 3-bit count
//     out) as the shared datapath. Everything else (FSM, shift reg, accumulator)
//     is inline.
// TESTING (CHUNKS=4, CNT_W=5)
//   1 in_data=24'h000000 accepted -> out_valid after 4 edges, out_count=0.
//   2 in_data=24'hFFFFFF -> out_count=24. Then 24'h03FF14 (chunks 20,60,63,0)
//     -> out_count=12.
//   3 Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_count stay
//     stable. in_ready stays 0. Then out_ready=1 -> IDLE next cycle.
//   4 Pulse in_valid with new data during RUN and DONE -> ignored. The result
//     matches the first word, and the second word is accepted only once back
//     in IDLE.
//   5 Assert rst for 1 cycle mid-RUN (idx=2) -> next cycle is IDLE with
//     out_valid=0 and in_ready=1. A fresh word then counts correctly.
//   6 Back-to-back stream of 8 random words with random out_ready -> every
//     out_count equals a reference $countones, in order, with no drops.

Source files
------------

// File: rtl/popcnt_pkg.sv
// Shared constants, FSM encoding and a constant clog2 helper for the popcount sequencer.
package popcnt_pkg;
  localparam int CHUNK_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index widths are never allowed to collapse to zero bits.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/onesin6.sv
// Combinational 6-bit popcount, the shared datapath of the sequencer.
module onesin6 (
  input  logic [5:0] d,
  output logic [2:0] cnt
);
  always_comb begin
    cnt = 3'd0;
    for (int i = 0; i < 6; i++) cnt = cnt + {2'b00, d[i]};
  end
endmodule

// File: rtl/popcnt_seq_ctrl.sv
// Counts ones in a CHUNKS*6-bit word by feeding one 6-bit chunk per cycle through a
// single onesin6 and accumulating; valid/ready on both the word and the result side.
module popcnt_seq_ctrl
  import popcnt_pkg::*;
#(
  parameter int CHUNKS = 4,
  parameter int CNT_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHUNK_W*CHUNKS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          out_count,
  output logic                      busy
);
  localparam int DATA_W = CHUNK_W * CHUNKS;
  localparam int IDX_W  = clog2(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  sh;
  logic [CNT_W-1:0]   acc, acc_nxt;
  logic [IDX_W-1:0]   idx;
  logic [2:0]         ones;

  onesin6 u_ones (
    .d   (sh[CHUNK_W-1:0]),
    .cnt (ones)
  );

  assign acc_nxt = acc + CNT_W'(ones);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      acc       <= '0;
      idx       <= '0;
      out_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          sh  <= in_data;
          acc <= '0;
          idx <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          sh  <= sh >> CHUNK_W;
          idx <= idx + IDX_W'(1);
          // Result register captures the final sum on the same edge that enters DONE.
          if (idx == LAST_IDX) out_count <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_popcnt_seq_ctrl.sv
// Directed checks of the popcount sequencer (CHUNKS=4, CNT_W=5) plus a short random stream.
module tb_popcnt_seq_ctrl;
  localparam int CHUNKS = 4;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [23:0]       in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  out_count;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  popcnt_seq_ctrl #(.CHUNKS(CHUNKS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until the edge that accepts it.
  task automatic accept(input logic [23:0] d);
    int t;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge: latency, result, then drain to IDLE.
  task automatic finish_word(input string tag, input int exp_cnt);
    repeat (CHUNKS - 1) tick();
    check({tag, "_early_valid"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_count"}, out_count, exp_cnt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, in_ready, 1);
  endtask

  logic [23:0] exp_q[$];
  int          got;
  bit          stable;

  initial begin
    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", out_count, 0);

    // 1: all zeros
    accept(24'h000000);
    check("t1_busy", busy, 1);
    finish_word("t1", 0);

    // 2: all ones, then mixed chunks 20,60,63,0
    accept(24'hFFFFFF);
    finish_word("t2a", 24);
    accept(24'h03FF14);
    finish_word("t2b", 12);

    // 3: consumer stalls 10 cycles in DONE
    accept(24'h123456);
    repeat (CHUNKS) tick();
    check("t3_valid", out_valid, 1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_count !== 5'd9 || in_ready !== 1'b0) stable = 1'b0;
      tick();
    end
    check("t3_stable", stable, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_idle", in_ready, 1);
    check("t3_drop", out_valid, 0);

    // 4: in_valid pulses during RUN and DONE are ignored
    accept(24'h000F0F);
    in_data = 24'h800001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("t4_valid", out_valid, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_ready_done", in_ready, 0);
    check("t4_count", out_count, 8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_idle", in_ready, 1);
    accept(24'h800001);
    finish_word("t4b", 2);

    // 5: reset mid-RUN at idx=2
    accept(24'hFFFFFF);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_count", out_count, 0);
    accept(24'hA5A5A5);
    finish_word("t5b", 12);

    // 6: stream of 8 random words with random back-pressure
    got = 0;
    fork
      begin
        for (int w = 0; w < 8; w++) begin
          logic [23:0] d;
          d = 24'($urandom);
          accept(d);
          exp_q.push_back(d);
          if ($urandom_range(0, 1) == 1) tick();
        end
      end
      begin
        for (int c = 0; c < 2000 && got < 8; c++) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("t6_underflow", 0, 1);
            else check($sformatf("t6_word%0d", got), out_count, $countones(exp_q.pop_front()));
            got++;
          end
        end
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    check("t6_all_words", got, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
